// File: rtl/periferico_rx_fifo.sv
// periferico_rx_fifo: receive stage that completes a 4-phase send/ack handshake per word,
// stores each captured word in a small FIFO and offers it downstream over valid/ready
// with first-word fall-through. Ack is withheld while the FIFO is full.
module periferico_rx_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              per_clock,
    input  logic              per_reset,
    input  logic              per_send,
    input  logic [DATA_W-1:0] in_per_dados,
    output logic              per_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dados,
    output logic [ADDR_W:0]   fifo_count,
    output logic [CNT_W-1:0]  rx_total
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  TOTAL_ONE = 1;

    state_t             state;
    state_t             state_next;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Handshake state register; reset wins over everything on the same edge
    always_ff @(posedge per_clock) begin
        if (per_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: capture once from IDLE when there is room, release ack when send drops
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (per_send && (fifo_count < FULL_CNT)) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!per_send) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign per_ack   = (state == ACK);
    assign out_valid = (fifo_count != '0);
    assign out_dados = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Storage array: written only on a capture, cleared on reset
    always_ff @(posedge per_clock) begin
        if (per_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_per_dados;
        end
    end

    // Pointers, occupancy and received-word total; push and pop may coincide
    always_ff @(posedge per_clock) begin
        if (per_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_total   <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                rx_total <= rx_total + TOTAL_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + COUNT_ONE;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_periferico_rx_fifo.sv
// tb_periferico_rx_fifo: directed scenarios plus randomized traffic, every cycle checked
// against a queue-based reference model of the handshake receiver and FIFO.
module tb_periferico_rx_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

    logic              per_clock;
    logic              per_reset;
    logic              per_send;
    logic [DATA_W-1:0] in_per_dados;
    logic              per_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_dados;
    logic [ADDR_W:0]   fifo_count;
    logic [CNT_W-1:0]  rx_total;

    // Reference model state
    logic [DATA_W-1:0] modelQueue [$];
    logic              modelAck;
    logic [CNT_W-1:0]  modelTotal;

    int checkCount;
    int failCount;

    periferico_rx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .per_clock   (per_clock),
        .per_reset   (per_reset),
        .per_send    (per_send),
        .in_per_dados(in_per_dados),
        .per_ack     (per_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dados   (out_dados),
        .fifo_count  (fifo_count),
        .rx_total    (rx_total)
    );

    // Free-running clock
    initial begin
        per_clock = 1'b0;
        forever #5 per_clock = ~per_clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare all outputs
    task automatic applyStimulus(input logic rst, input logic send, input logic [DATA_W-1:0] data,
                                 input logic ready);
        logic doPush;
        logic doPop;
        logic [DATA_W-1:0] dropped;
        per_reset    = rst;
        per_send     = send;
        in_per_dados = data;
        out_ready    = ready;
        @(posedge per_clock);
        #1;
        if (rst) begin
            modelQueue.delete();
            modelAck   = 1'b0;
            modelTotal = '0;
        end else begin
            doPush = !modelAck && send && (modelQueue.size() < DEPTH);
            doPop  = (modelQueue.size() > 0) && ready;
            if (doPop) begin
                dropped = modelQueue.pop_front();
            end
            if (doPush) begin
                modelQueue.push_back(data);
                modelTotal = modelTotal + 1'b1;
            end
            if (modelAck) begin
                if (!send) modelAck = 1'b0;
            end else if (doPush) begin
                modelAck = 1'b1;
            end
        end
        checkOutput("per_ack", 32'(per_ack), 32'(modelAck));
        checkOutput("out_valid", 32'(out_valid), 32'(modelQueue.size() != 0));
        checkOutput("fifo_count", 32'(fifo_count), 32'(modelQueue.size()));
        checkOutput("rx_total", 32'(rx_total), 32'(modelTotal));
        if (modelQueue.size() != 0) begin
            checkOutput("out_dados", 32'(out_dados), 32'(modelQueue[0]));
        end
    endtask

    // Full 4-phase handshake for one word, bounded so a stuck ack cannot hang the run
    task automatic sendWord(input logic [DATA_W-1:0] data, input logic ready);
        int guard;
        guard = 0;
        do begin
            applyStimulus(1'b0, 1'b1, data, ready);
            guard++;
        end while (!modelAck && guard < 50);
        if (!modelAck) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL handshake_timeout observed=0 expected=1");
        end
        applyStimulus(1'b0, 1'b0, data, ready);
    endtask

    initial begin
        logic sendHeld;
        logic [DATA_W-1:0] sendData;
        checkCount   = 0;
        failCount    = 0;
        modelAck     = 1'b0;
        modelTotal   = '0;
        per_reset    = 1'b1;
        per_send     = 1'b0;
        in_per_dados = '0;
        out_ready    = 1'b0;

        // Scenario 1: reset, then a single handshake with literal expectations
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
        checkOutput("first_ack", 32'(per_ack), 32'd1);
        checkOutput("first_data", 32'(out_dados), 32'h5);
        applyStimulus(1'b0, 1'b0, 4'h5, 1'b0);
        checkOutput("ack_drop", 32'(per_ack), 32'd0);

        // Scenario 2: fill to full, sender stalls, a pop frees room, then drain in order
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 1; i <= 4; i++) sendWord(DATA_W'(i), 1'b0);
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
        checkOutput("full_no_ack", 32'(per_ack), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
        checkOutput("pop_no_bypass", 32'(per_ack), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
        checkOutput("ack_after_pop", 32'(per_ack), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h5, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("drained", 32'(out_valid), 32'd0);

        // Scenario 3: capture and pop on the same edge at count 2
        sendWord(4'hA, 1'b0);
        sendWord(4'hB, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hC, 1'b1);
        checkOutput("pushpop_count", 32'(fifo_count), 32'd2);
        checkOutput("pushpop_head", 32'(out_dados), 32'hB);
        applyStimulus(1'b0, 1'b0, 4'hC, 1'b0);

        // Scenario 4: reset while ack is high and three words are stored
        applyStimulus(1'b0, 1'b1, 4'hD, 1'b0);
        checkOutput("pre_reset_count", 32'(fifo_count), 32'd3);
        applyStimulus(1'b1, 1'b1, 4'hD, 1'b0);
        checkOutput("mid_reset_ack", 32'(per_ack), 32'd0);
        checkOutput("mid_reset_total", 32'(rx_total), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);

        // Scenario 5: ten back-to-back handshakes with consumer always ready
        for (int i = 0; i < 10; i++) sendWord(DATA_W'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("b2b_total", 32'(rx_total), 32'd10);
        checkOutput("b2b_count", 32'(fifo_count), 32'd0);

        // Scenario 6: 256 handshakes wrap the total back to zero
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 256; i++) sendWord(DATA_W'($urandom), 1'b1);
        checkOutput("wrap_total", 32'(rx_total), 32'd0);

        // Randomized traffic: protocol-obeying sender, random consumer, rare resets
        sendHeld = 1'b0;
        sendData = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!sendHeld && !modelAck && $urandom_range(0, 2) == 0) begin
                sendHeld = 1'b1;
                sendData = DATA_W'($urandom);
            end else if (sendHeld && modelAck && $urandom_range(0, 1) == 0) begin
                sendHeld = 1'b0;
            end
            applyStimulus($urandom_range(0, 199) == 0, sendHeld, sendData,
                          $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
